// File: rtl/axi_burst_write_master.sv
// AXI-style burst write master: splits a (start address, beat count) command
// into AW/W bursts limited by the maximum AXI length and by 4KB pages.
// Only one burst is in flight; the next AW waits for the previous wlast.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// AW     | presenting the burst address until awready
// W      | streaming beats straight from s_data to the W channel
// DONE   | one-cycle completion pulse
module axi_burst_write_master #(
  parameter int AXI_ADDR_BITWIDTH = 32,
  parameter int AXI_DATA_BITWIDTH = 64,
  parameter int AXI_LEN_BITWIDTH  = 4,
  parameter int AXI_STRB_BITWIDTH = 8,
  parameter int CMD_LEN_BITWIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [AXI_ADDR_BITWIDTH-1:0] cmd_addr,
  input  logic [CMD_LEN_BITWIDTH-1:0]  cmd_beats,
  input  logic                         s_data_valid,
  output logic                         s_data_ready,
  input  logic [AXI_DATA_BITWIDTH-1:0] s_data,
  input  logic [AXI_STRB_BITWIDTH-1:0] s_strb,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [AXI_ADDR_BITWIDTH-1:0] m_axi_awaddr,
  output logic [AXI_LEN_BITWIDTH-1:0]  m_axi_awlen,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  output logic [AXI_DATA_BITWIDTH-1:0] m_axi_wdata,
  output logic [AXI_STRB_BITWIDTH-1:0] m_axi_wstrb,
  output logic                         m_axi_wlast,
  output logic                         busy,
  output logic                         done
);

  localparam int BYTES     = AXI_DATA_BITWIDTH / 8;
  localparam int BL        = $clog2(BYTES);
  localparam int MAX_BEATS = 2 ** AXI_LEN_BITWIDTH;
  // Common compare width: must hold the full command count, 4096 and MAX_BEATS.
  localparam int MW0 = (CMD_LEN_BITWIDTH > 14) ? CMD_LEN_BITWIDTH : 14;
  localparam int MW  = (MW0 > AXI_LEN_BITWIDTH + 1) ? MW0 : AXI_LEN_BITWIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_DONE} state_t;

  state_t                       r_state;
  logic [AXI_ADDR_BITWIDTH-1:0] r_addr;
  logic [CMD_LEN_BITWIDTH-1:0]  r_rem;
  logic [AXI_LEN_BITWIDTH:0]    r_burst;
  logic [AXI_LEN_BITWIDTH-1:0]  r_beat_cnt;
  logic                         r_awvalid;
  logic [AXI_ADDR_BITWIDTH-1:0] r_awaddr;
  logic [AXI_LEN_BITWIDTH-1:0]  r_awlen;

  logic [AXI_ADDR_BITWIDTH-1:0] w_cmd_addr;
  logic [AXI_LEN_BITWIDTH:0]    w_burst_cmd;
  logic [AXI_LEN_BITWIDTH:0]    w_burst_nxt;
  logic [CMD_LEN_BITWIDTH-1:0]  w_rem_nxt;
  logic [AXI_ADDR_BITWIDTH-1:0] w_addr_nxt;
  logic                         w_in_w;
  logic                         w_last;
  logic                         w_w_hs;

  // Beats in the next burst: remaining count, AXI length cap and distance to
  // the next 4KB page (always at least one beat for an aligned address).
  function automatic logic [AXI_LEN_BITWIDTH:0] f_burst(
    input logic [CMD_LEN_BITWIDTH-1:0] rem,
    input logic [11:0]                 page_off
  );
    logic [MW-1:0] l_rem;
    logic [MW-1:0] l_max;
    logic [MW-1:0] l_page;
    logic [MW-1:0] l_min;
    l_rem  = MW'(rem);
    l_max  = MW'(MAX_BEATS);
    l_page = MW'((13'd4096 - {1'b0, page_off}) >> BL);
    l_min  = (l_rem < l_max) ? l_rem : l_max;
    if (l_page < l_min) l_min = l_page;
    return l_min[AXI_LEN_BITWIDTH:0];
  endfunction

  assign w_cmd_addr  = cmd_addr & ~AXI_ADDR_BITWIDTH'(BYTES - 1);
  assign w_burst_cmd = f_burst(cmd_beats, w_cmd_addr[11:0]);
  assign w_rem_nxt   = r_rem - CMD_LEN_BITWIDTH'(r_burst);
  assign w_addr_nxt  = r_addr + (AXI_ADDR_BITWIDTH'(r_burst) << BL);
  assign w_burst_nxt = f_burst(w_rem_nxt, w_addr_nxt[11:0]);

  assign w_in_w = (r_state == S_W);
  assign w_last = w_in_w && (r_beat_cnt == r_awlen);
  assign w_w_hs = w_in_w && s_data_valid && m_axi_wready;

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_wvalid  = w_in_w && s_data_valid;
  assign s_data_ready  = w_in_w && m_axi_wready;
  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = s_strb;
  assign m_axi_wlast   = w_last;

  // Sequencer: command capture, burst sizing, AW handshake and beat counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_burst    <= '0;
      r_beat_cnt <= '0;
      r_awvalid  <= 1'b0;
      r_awaddr   <= '0;
      r_awlen    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr <= w_cmd_addr;
            r_rem  <= cmd_beats;
            if (cmd_beats == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state   <= S_AW;
              r_burst   <= w_burst_cmd;
              r_awvalid <= 1'b1;
              r_awaddr  <= w_cmd_addr;
              r_awlen   <= w_burst_cmd[AXI_LEN_BITWIDTH-1:0] - AXI_LEN_BITWIDTH'(1);
            end
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            r_awvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= S_W;
          end
        end
        S_W: begin
          if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + AXI_LEN_BITWIDTH'(1);
            if (w_last) begin
              r_rem  <= w_rem_nxt;
              r_addr <= w_addr_nxt;
              if (w_rem_nxt == '0) begin
                r_state <= S_DONE;
              end else begin
                r_state   <= S_AW;
                r_burst   <= w_burst_nxt;
                r_awvalid <= 1'b1;
                r_awaddr  <= w_addr_nxt;
                r_awlen   <= w_burst_nxt[AXI_LEN_BITWIDTH-1:0] - AXI_LEN_BITWIDTH'(1);
              end
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
